mastermind_game_ctrl: RTL and testbench
=======================================

# mastermind_game_ctrl

Game sequencer for the Mastermind top level. Latches the secret code from the PRNG, accepts guesses one turn at a time, and runs a multi-cycle scoring sequence (exact and colour-only matches). It drives history writes and the turn count, and signals win, loss and game-over to history, feedback and turn display.

## Interface
- MAX_TURNS, 8: turns per game (1..8).
- TIMEOUT_TICKS, 30: tick pulses allowed per turn (timeout feature only).
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  debounced select level; rising edge starts a game
- submit  in  1  debounced submit level; rising edge ends the turn
- tick  in  1  one-cycle enable pulse (1 Hz); ignored unless timeout compiled in
- rnd_code  in  12  PRNG output, peg0 = [2:0] … peg3 = [11:9]
- guess  in  12  current guess, same packing
- code  out  12  latched secret code
- hist_wr_en  out  1  one-cycle history write strobe
- hist_wr_idx  out  3  turn index being written
- hist_wr_data  out  12  guess being written
- exact  out  3  pegs with correct colour and position (0..4)
- partial  out  3  correct colour, wrong position (0..4)
- score_valid  out  1  one-cycle pulse; exact/partial updated
- turn  out  3  current turn, 0-based
- busy  out  1  high in SCORE_EXACT/SCORE_COLOR/RESULT
- won  out  1  level, high in WON
- lost  out  1  level, high in LOST
- game_over  out  1  one-cycle pulse on entry to WON or LOST

## Operation
- start and submit are edge-detected internally: registered previous value; edge = level & ~prev. prev resets to 0.
- States: IDLE, GUESS, SCORE_EXACT, SCORE_COLOR, RESULT, WON, LOST.
- IDLE: start edge → latch rnd_code into code, turn=0, go to GUESS.
- GUESS: submit edge → latch guess into an internal register (the scorer reads this copy only), clear exact count, go to SCORE_EXACT.
- SCORE_EXACT: 4 cycles, peg p = 0..3. Increment exact if code[p]==guess_l[p].
- SCORE_COLOR: 8 cycles, colour c = 0..7. Add min(count of c in code, count of c in guess_l) to a 3-bit match sum.
- RESULT: 1 cycle.
  - partial = match − exact.
  - exact and partial registered.
  - score_valid=1, hist_wr_en=1, hist_wr_idx=turn, hist_wr_data=guess_l.
  - Next state: exact==4 → WON; else turn==MAX_TURNS−1 → LOST; else turn+1, GUESS.
- WON/LOST: hold all outputs. start edge → latch rnd_code, turn=0, exact=partial=0, GUESS.
- Boundaries:
  - start is ignored in GUESS and while busy; there is no mid-game restart.
  - submit is ignored outside GUESS and is not queued.
  - A start and submit edge in the same GUESS cycle: submit wins.
  - Duplicate colours in the code or guess are legal; the min-count rule handles them.
  - match never exceeds 4; no overflow.
- Reset: state IDLE; all outputs 0; internal counters and latches 0.

## Timing
- Submit edge sampled at cycle E (state GUESS).
- SCORE_EXACT occupies E+1..E+4; SCORE_COLOR occupies E+5..E+12.
- RESULT at E+13: score_valid, hist_wr_en and new exact/partial are visible at the end of that cycle.
- Next GUESS, WON or LOST at E+14; game_over pulses in that same cycle.
- busy is high E+1..E+13.
- Start edge at cycle S: code valid and state GUESS from S+1.
- Asynchronous reset at any point, including mid-score, aborts to IDLE immediately. No history write is issued for the aborted turn.

## Configuration
- MASTERMIND_TURN_TIMEOUT_EN defined:
  - A 5-bit tick counter clears on GUESS entry and increments on each tick while in GUESS.
  - When it reaches TIMEOUT_TICKS, a forced submit occurs with the current guess, identical to a submit edge.
  - A real submit edge in the same cycle counts once.
- Not defined: tick is ignored, the counter is not built, and a turn never ends without submit.

## Structure
- Package mastermind_pkg:
  - color_t (3-bit); code_t (4×color_t, packed 12 bits).
  - NUM_PEGS=4, NUM_COLORS=8.
  - state enum game_state_t.
- Sub-module mastermind_scorer:
  - Owns the SCORE_EXACT/SCORE_COLOR counters and the exact/match accumulators.
  - Interface: go pulse in; code/guess in; done pulse, exact, partial out.
- The top FSM in mastermind_game_ctrl sequences mastermind_scorer.

## Test plan
- Reset mid-SCORE_COLOR → next cycle state IDLE; all outputs 0; no hist_wr_en.
- rnd_code=pegs(1,2,3,4), start edge; guess (1,2,3,4) submit → at E+13: exact=4, partial=0, hist_wr_idx=0; E+14: won=1, game_over pulse.
- Code (1,2,3,4), guess (4,3,2,1) → exact=0, partial=4, turn becomes 1.
- Code (5,5,1,2), guess (5,1,5,7) → exact=1, partial=2.
- MAX_TURNS=8; 8 wrong guesses → hist_wr_idx 0..7; lost=1 after 8th RESULT; submit ignored afterwards; start edge → turn=0, new code latched.
- MASTERMIND_TURN_TIMEOUT_EN, TIMEOUT_TICKS=3; three tick pulses in GUESS, no submit → scoring starts the cycle after the 3rd tick; the history write carries the guess at that cycle.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared types for the Mastermind game controller: peg/code packing, FSM states
// and a colour-counting helper used by the scorer.
package mastermind_pkg;

  localparam int NUM_PEGS   = 4;
  localparam int NUM_COLORS = 8;

  typedef logic [2:0] color_t;
  typedef color_t [NUM_PEGS-1:0] code_t;

  typedef enum logic [2:0] {
    IDLE,
    GUESS,
    SCORE_EXACT,
    SCORE_COLOR,
    RESULT,
    WON,
    LOST
  } game_state_t;

  function automatic logic [2:0] color_count(input code_t c, input color_t col);
    logic [2:0] n;
    n = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (c[p] == col) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: 4 cycles of per-peg exact compare, then 8 cycles
// of per-colour min-count accumulation; exact/partial are registered on completion.
module mastermind_scorer
  import mastermind_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        clr,
  input  logic [11:0] code,
  input  logic [11:0] guess,
  output logic        exact_done,
  output logic        done,
  output logic [2:0]  exact,
  output logic [2:0]  partial
);

  typedef enum logic [1:0] {PH_IDLE, PH_EXACT, PH_COLOR} phase_t;

  phase_t     phase;
  code_t      code_c;
  code_t      guess_c;
  logic [2:0] cnt;
  logic [2:0] exact_acc;
  logic [2:0] match_acc;
  logic [2:0] cnt_code;
  logic [2:0] cnt_guess;
  logic [2:0] min_c;

  assign code_c  = code;
  assign guess_c = guess;

  always_comb begin
    cnt_code  = color_count(code_c, cnt);
    cnt_guess = color_count(guess_c, cnt);
    min_c     = (cnt_code < cnt_guess) ? cnt_code : cnt_guess;
  end

  // exact_done/done flag the final cycle of each phase so the controller steps in lockstep
  assign exact_done = (phase == PH_EXACT) && (cnt == 3'd3);
  assign done       = (phase == PH_COLOR) && (cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= PH_IDLE;
      cnt       <= '0;
      exact_acc <= '0;
      match_acc <= '0;
      exact     <= '0;
      partial   <= '0;
    end else begin
      if (clr) begin
        exact   <= '0;
        partial <= '0;
      end
      if (go) begin
        phase     <= PH_EXACT;
        cnt       <= '0;
        exact_acc <= '0;
        match_acc <= '0;
      end else begin
        case (phase)
          PH_EXACT: begin
            if (code_c[cnt[1:0]] == guess_c[cnt[1:0]]) exact_acc <= exact_acc + 3'd1;
            if (exact_done) begin
              phase <= PH_COLOR;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          PH_COLOR: begin
            match_acc <= match_acc + min_c;
            cnt       <= cnt + 3'd1;
            if (done) begin
              phase   <= PH_IDLE;
              exact   <= exact_acc;
              partial <= match_acc + min_c - exact_acc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: code latch, turn handling, scoring sequence, history writes.
// Optional per-turn timeout enabled by defining MASTERMIND_TURN_TIMEOUT_EN.
module mastermind_game_ctrl
  import mastermind_pkg::*;
#(
  parameter int MAX_TURNS     = 8,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        submit,
  input  logic        tick,
  input  logic [11:0] rnd_code,
  input  logic [11:0] guess,
  output logic [11:0] code,
  output logic        hist_wr_en,
  output logic [2:0]  hist_wr_idx,
  output logic [11:0] hist_wr_data,
  output logic [2:0]  exact,
  output logic [2:0]  partial,
  output logic        score_valid,
  output logic [2:0]  turn,
  output logic        busy,
  output logic        won,
  output logic        lost,
  output logic        game_over
);

  game_state_t state, state_nx;
  logic        start_prev, submit_prev;
  logic        start_edge, submit_edge, turn_end;
  logic [11:0] code_r, guess_l;
  logic [2:0]  turn_r;
  logic        sc_go, sc_clr, sc_exact_done, sc_done;
  logic        game_over_r;

  assign start_edge  = start & ~start_prev;
  assign submit_edge = submit & ~submit_prev;

`ifdef MASTERMIND_TURN_TIMEOUT_EN
  logic [4:0] tick_cnt;
  logic       timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tick_cnt <= '0;
    else if (state != GUESS) tick_cnt <= '0;
    else if (tick)           tick_cnt <= tick_cnt + 5'd1;
  end

  // The tick that reaches the limit forces the submit in its own cycle; OR-ing keeps a coincident real submit single
  assign timeout  = (state == GUESS) && tick && (tick_cnt == 5'(TIMEOUT_TICKS - 1));
  assign turn_end = submit_edge | timeout;
`else
  logic unused_cfg;
  assign unused_cfg = ^{tick, 5'(TIMEOUT_TICKS)};
  assign turn_end   = submit_edge;
`endif

  mastermind_scorer u_scorer (
    .clk        (clk),
    .rst        (rst),
    .go         (sc_go),
    .clr        (sc_clr),
    .code       (code_r),
    .guess      (guess_l),
    .exact_done (sc_exact_done),
    .done       (sc_done),
    .exact      (exact),
    .partial    (partial)
  );

  always_comb begin
    state_nx = state;
    sc_go    = 1'b0;
    sc_clr   = 1'b0;
    case (state)
      IDLE, WON, LOST: begin
        if (start_edge) begin
          state_nx = GUESS;
          sc_clr   = 1'b1;
        end
      end
      GUESS: begin
        if (turn_end) begin
          state_nx = SCORE_EXACT;
          sc_go    = 1'b1;
        end
      end
      SCORE_EXACT: if (sc_exact_done) state_nx = SCORE_COLOR;
      SCORE_COLOR: if (sc_done) state_nx = RESULT;
      RESULT: begin
        if (exact == 3'd4)                      state_nx = WON;
        else if (turn_r == 3'(MAX_TURNS - 1)) state_nx = LOST;
        else                                    state_nx = GUESS;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      start_prev  <= 1'b0;
      submit_prev <= 1'b0;
      code_r      <= '0;
      guess_l     <= '0;
      turn_r      <= '0;
      game_over_r <= 1'b0;
    end else begin
      state       <= state_nx;
      start_prev  <= start;
      submit_prev <= submit;
      game_over_r <= (state == RESULT) && (state_nx != GUESS);
      if (sc_clr) begin
        code_r <= rnd_code;
        turn_r <= '0;
      end
      if (sc_go) guess_l <= guess;
      if ((state == RESULT) && (state_nx == GUESS)) turn_r <= turn_r + 3'd1;
    end
  end

  assign code         = code_r;
  assign turn         = turn_r;
  assign hist_wr_en   = (state == RESULT);
  assign score_valid  = (state == RESULT);
  assign hist_wr_idx  = turn_r;
  assign hist_wr_data = guess_l;
  assign busy         = (state == SCORE_EXACT) || (state == SCORE_COLOR) || (state == RESULT);
  assign won          = (state == WON);
  assign lost         = (state == LOST);
  assign game_over    = game_over_r;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed bench for mastermind_game_ctrl: table of scoring vectors plus
// hand-written sequences for reset abort, loss after MAX_TURNS and turn timeout.
module tb_mastermind_game_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, submit, tick;
  logic [11:0] rnd_code, guess;
  logic [11:0] code, hist_wr_data;
  logic        hist_wr_en, score_valid, busy, won, lost, game_over;
  logic [2:0]  hist_wr_idx, exact, partial, turn;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mastermind_game_ctrl #(.MAX_TURNS(8), .TIMEOUT_TICKS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .submit       (submit),
    .tick         (tick),
    .rnd_code     (rnd_code),
    .guess        (guess),
    .code         (code),
    .hist_wr_en   (hist_wr_en),
    .hist_wr_idx  (hist_wr_idx),
    .hist_wr_data (hist_wr_data),
    .exact        (exact),
    .partial      (partial),
    .score_valid  (score_valid),
    .turn         (turn),
    .busy         (busy),
    .won          (won),
    .lost         (lost),
    .game_over    (game_over)
  );

  typedef struct {
    logic [11:0] code;
    logic [11:0] guess;
    logic [2:0]  ex;
    logic [2:0]  pa;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [11:0] pegs(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Start edge in cycle S; returns in S+1 (state GUESS)
  task automatic start_game(input logic [11:0] rc);
    start = 1'b0;
    step();
    rnd_code = rc;
    start    = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Submit edge in cycle E; returns in cycle E+13 (RESULT)
  task automatic play(input logic [11:0] g);
    submit = 1'b0;
    step();
    guess  = g;
    submit = 1'b1;
    chk("busy_at_E", busy, 0);
    step();
    chk("busy_at_E1", busy, 1);
    submit = 1'b0;
    guess  = ~g;
    repeat (12) step();
  endtask

  initial begin
    logic       seen;
    logic [2:0] ex_t, pa_t;

    vecs[0] = '{pegs(1,2,3,4), pegs(1,2,3,4), 3'd4, 3'd0};
    vecs[1] = '{pegs(1,2,3,4), pegs(4,3,2,1), 3'd0, 3'd4};
    vecs[2] = '{pegs(5,5,1,2), pegs(5,1,5,7), 3'd1, 3'd2};
    vecs[3] = '{pegs(0,0,0,0), pegs(7,7,7,7), 3'd0, 3'd0};
    vecs[4] = '{pegs(0,0,0,0), pegs(0,0,0,0), 3'd4, 3'd0};
    vecs[5] = '{pegs(1,1,2,2), pegs(2,2,1,1), 3'd0, 3'd4};
    vecs[6] = '{pegs(3,3,3,4), pegs(3,4,4,4), 3'd2, 3'd0};
    vecs[7] = '{pegs(7,6,5,4), pegs(6,7,4,0), 3'd0, 3'd3};

    rst = 1'b1; start = 1'b0; submit = 1'b0; tick = 1'b0;
    rnd_code = pegs(1,2,3,4); guess = '0;
    step();
    step();
    chk("rst_code", code, 0);
    chk("rst_outs", {hist_wr_en, score_valid, busy, won, lost, game_over}, 0);
    chk("rst_score", {exact, partial, turn, hist_wr_idx}, 0);
    chk("rst_hist_data", hist_wr_data, 0);
    rst = 1'b0;
    step();
    chk("idle_after_rst", {busy, won, lost, game_over}, 0);

    // Table: fresh game per vector, single guess
    for (int i = 0; i < 8; i++) begin
      pulse_rst();
      start_game(vecs[i].code);
      chk($sformatf("v%0d_code", i), code, vecs[i].code);
      play(vecs[i].guess);
      chk($sformatf("v%0d_valid", i), {score_valid, hist_wr_en, busy}, 3'b111);
      chk($sformatf("v%0d_exact", i), exact, vecs[i].ex);
      chk($sformatf("v%0d_partial", i), partial, vecs[i].pa);
      chk($sformatf("v%0d_hidx", i), hist_wr_idx, 0);
      chk($sformatf("v%0d_hdata", i), hist_wr_data, vecs[i].guess);
      step();
      chk($sformatf("v%0d_won", i), won, (vecs[i].ex == 3'd4));
      chk($sformatf("v%0d_gover", i), game_over, (vecs[i].ex == 3'd4));
      chk($sformatf("v%0d_turn", i), turn, (vecs[i].ex == 3'd4) ? 0 : 1);
      chk($sformatf("v%0d_idle_strobes", i), {score_valid, hist_wr_en, busy}, 0);
    end

    // Asynchronous reset mid SCORE_COLOR aborts without a history write
    pulse_rst();
    start_game(pegs(1,2,3,4));
    submit = 1'b0;
    step();
    guess  = pegs(1,2,3,4);
    submit = 1'b1;
    step();
    submit = 1'b0;
    repeat (6) step();
    chk("midscore_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", {hist_wr_en, score_valid, busy, won, lost, game_over}, 0);
    chk("abort_code_turn", {code, turn}, 0);
    step();
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (hist_wr_en || busy || won) seen = 1'b1;
      step();
    end
    chk("abort_no_write", seen, 0);

    // Eight wrong guesses lose the game; start ignored mid-game
    pulse_rst();
    start_game(pegs(1,2,3,4));
    rnd_code = pegs(6,6,6,6);
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored_code", code, pegs(1,2,3,4));
    chk("start_ignored_busy", busy, 0);
    for (int t = 0; t < 8; t++) begin
      ex_t = (t == 4) ? 3'd2 : 3'd1;
      pa_t = (t == 2 || t == 3) ? 3'd1 : 3'd0;
      play(pegs(1,0,0,t));
      chk($sformatf("t%0d_hidx", t), hist_wr_idx, t);
      chk($sformatf("t%0d_hdata", t), hist_wr_data, pegs(1,0,0,t));
      chk($sformatf("t%0d_score", t), {exact, partial}, {ex_t, pa_t});
      step();
      if (t < 7) chk($sformatf("t%0d_next", t), {turn, lost, game_over}, {3'(t + 1), 2'b00});
      else       chk("t7_lost", {turn, lost, game_over}, {3'd7, 2'b11});
    end
    step();
    chk("lost_hold", {lost, game_over}, 2'b10);
    submit = 1'b0;
    step();
    submit = 1'b1;
    seen   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (hist_wr_en || busy || !lost) seen = 1'b1;
    end
    submit = 1'b0;
    chk("submit_ignored_lost", seen, 0);
    start_game(pegs(2,7,0,5));
    chk("restart_code", code, pegs(2,7,0,5));
    chk("restart_state", {turn, lost, won, busy}, 0);
    chk("restart_score", {exact, partial}, 0);

    // Turn timeout after three ticks in GUESS
    submit = 1'b0;
    guess  = pegs(3,1,4,1);
    tick = 1'b1; step(); tick = 1'b0; step();
    tick = 1'b1; step(); tick = 1'b0; step();
    tick = 1'b1; step(); tick = 1'b0;
    guess = pegs(0,0,0,0);
`ifdef MASTERMIND_TURN_TIMEOUT_EN
    chk("timeout_busy", busy, 1);
    repeat (12) step();
    chk("timeout_write", hist_wr_en, 1);
    chk("timeout_hdata", hist_wr_data, pegs(3,1,4,1));
`else
    chk("notimeout_busy", busy, 0);
    seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick = c[0];
      step();
      if (busy || hist_wr_en) seen = 1'b1;
    end
    tick = 1'b0;
    chk("notimeout_idle", seen, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
